stopwatch_ctrl: RTL

Mode controller and time-base scheduler for the four-digit MM:SS stopwatch counter. It debounces the user controls and runs the RUN/PAUSE/ADJUST state machine. It generates the single-cycle count enable and adjust-rate ticks, and holds the BCD adjust value that drives the counter's `adj_dig_*` inputs. It sits between the board buttons/switches and the counter, which consumes its outputs unchanged.

---
 rtl/stopwatch_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Mode controller and time-base scheduler for the MM:SS stopwatch counter.
// Conditions the raw controls, runs the RUN/PAUSE/ADJUST FSM, produces the
// count-enable and clear pulses, and holds the BCD adjust value.
// Optional feature: define STOPWATCH_BLINK_EN to enable the adjust-field blink.
module stopwatch_ctrl #(
  parameter int unsigned DIV_1HZ         = 100_000_000,
  parameter int unsigned DIV_2HZ         = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_pause,
  input  logic       btn_clear,
  input  logic       sw_adj,
  input  logic       sw_sel,
  input  logic [3:0] cur_min_tens,
  input  logic [3:0] cur_min_ones,
  input  logic [3:0] cur_sec_tens,
  input  logic [3:0] cur_sec_ones,
  output logic [1:0] state,
  output logic       count_en,
  output logic       clear,
  output logic [3:0] adj_min_tens,
  output logic [3:0] adj_min_ones,
  output logic [3:0] adj_sec_tens,
  output logic [3:0] adj_sec_ones,
  output logic       blink
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned Div1W = $clog2(DIV_1HZ);
  localparam int unsigned Div2W = $clog2(DIV_2HZ);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StPause  = 2'd1,
    StAdjust = 2'd2
  } state_e;

  // Raw input bit order: 0 pause, 1 clear, 2 adjust switch, 3 field select.
  logic [3:0]     raw;
  logic [3:0]     sync1_q, sync2_q, db_q;
  logic [DbW-1:0] db_cnt_q [4];
  logic [1:0]     btn_prev_q;
  logic           pause_pulse, clear_pulse;

  state_e state_q, state_d;
  logic   in_run, in_adj, adj_entry;

  logic [Div1W-1:0] div1_q;
  logic [Div2W-1:0] div2_q;
  logic             tick2;
  logic             count_en_q, clear_q;
  logic [3:0]       adj_mt_q, adj_mo_q, adj_st_q, adj_so_q;
  logic             min_ok, sec_ok;

  assign raw = {sw_sel, sw_adj, btn_clear, btn_pause};

  // Two-flop synchronizers and per-input debounce counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Previous debounced button levels for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) btn_prev_q <= '0;
    else        btn_prev_q <= db_q[1:0];
  end

  assign pause_pulse = db_q[0] & ~btn_prev_q[0];
  assign clear_pulse = db_q[1] & ~btn_prev_q[1];

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StPause;
    else        state_q <= state_d;
  end

  // FSM next state; the adjust switch overrides any pause pulse.
  always_comb begin
    state_d = state_q;
    if (db_q[2]) begin
      state_d = StAdjust;
    end else begin
      unique case (state_q)
        StRun:    if (pause_pulse) state_d = StPause;
        StPause:  if (pause_pulse) state_d = StRun;
        StAdjust: state_d = StPause;
        default:  state_d = StPause;
      endcase
    end
  end

  // FSM outputs and state decodes.
  always_comb begin
    state  = state_q;
    in_run = (state_q == StRun);
    in_adj = (state_q == StAdjust);
  end

  assign adj_entry = !in_adj && (state_d == StAdjust);
  assign tick2     = in_adj && (div2_q == Div2W'(DIV_2HZ - 1));

  // 1 Hz divider: advances only in RUN so a resumed run keeps its partial second.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div1_q     <= '0;
      count_en_q <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      clear_q <= clear_pulse;
      if (clear_pulse) begin
        div1_q     <= '0;
        count_en_q <= 1'b0;
      end else if (in_run && (div1_q == Div1W'(DIV_1HZ - 1))) begin
        div1_q     <= '0;
        count_en_q <= 1'b1;
      end else begin
        if (in_run) div1_q <= div1_q + 1'b1;
        count_en_q <= 1'b0;
      end
    end
  end

  // 2 Hz divider: restarts on ADJUST entry and counts only while adjusting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        div2_q <= '0;
    else if (clear_pulse || adj_entry) div2_q <= '0;
    else if (tick2)                    div2_q <= '0;
    else if (in_adj)                   div2_q <= div2_q + 1'b1;
  end

  function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
    logic [7:0] res;
    if (ones >= 4'd9) res = (tens >= 4'd5) ? 8'h00 : {tens + 4'd1, 4'd0};
    else              res = {tens, ones + 4'd1};
    return res;
  endfunction

  assign min_ok = (cur_min_tens <= 4'd5) && (cur_min_ones <= 4'd9);
  assign sec_ok = (cur_sec_tens <= 4'd5) && (cur_sec_ones <= 4'd9);

  // Adjust value: snapshot on entry, bump the selected field on each 2 Hz tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {adj_mt_q, adj_mo_q, adj_st_q, adj_so_q} <= '0;
    end else if (clear_pulse) begin
      {adj_mt_q, adj_mo_q, adj_st_q, adj_so_q} <= '0;
    end else if (adj_entry) begin
      {adj_mt_q, adj_mo_q} <= min_ok ? {cur_min_tens, cur_min_ones} : 8'h00;
      {adj_st_q, adj_so_q} <= sec_ok ? {cur_sec_tens, cur_sec_ones} : 8'h00;
    end else if (tick2) begin
      if (db_q[3]) {adj_mt_q, adj_mo_q} <= bcd_inc(adj_mt_q, adj_mo_q);
      else         {adj_st_q, adj_so_q} <= bcd_inc(adj_st_q, adj_so_q);
    end
  end

`ifdef STOPWATCH_BLINK_EN
  logic blink_q;

  // Blink toggles at each half period of the 2 Hz divider while adjusting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       blink_q <= 1'b0;
    else if (!in_adj) blink_q <= 1'b0;
    else if ((div2_q == '0) || (div2_q == Div2W'(DIV_2HZ / 2))) blink_q <= ~blink_q;
  end

  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif

  assign count_en     = count_en_q;
  assign clear        = clear_q;
  assign adj_min_tens = adj_mt_q;
  assign adj_min_ones = adj_mo_q;
  assign adj_sec_tens = adj_st_q;
  assign adj_sec_ones = adj_so_q;

endmodule
